bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/disp_pkg.sv | 15 +
 rtl/bcd_nibble_adj.sv | 7 +
 rtl/bcd_to_bin.sv | 108 ++++++++++
 tb/tb_bcd_to_bin.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the display path's BCD-to-binary converter.
package disp_pkg;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int CNT_W  = 4;
    localparam int SHIFTS = 14;
    localparam int BCD_W  = DIGITS * 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFTS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/bcd_nibble_adj.sv
// One BCD digit correction step of reverse double-dabble: nibble >= 8 ? nibble-3 : nibble.
module bcd_nibble_adj (
    input  logic [3:0] nib,
    output logic [3:0] adj
);
    assign adj = (nib >= 4'd8) ? nib - 4'd3 : nib;
endmodule

// File: rtl/bcd_to_bin.sv
// Iterative 4-digit BCD to 14-bit binary converter (reverse double-dabble, one bit per cycle).
// Optional digit validation when BCD2BIN_ERR_EN is defined; otherwise err is tied low.
module bcd_to_bin
    import disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BIN_W-1:0] bin_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t           state, state_nxt;
    logic [BCD_W-1:0] bcd_sr, bcd_shr, bcd_adj;
    // The 14th (final) bit lands directly in bin_out, so only 13 bits are held here.
    logic [BIN_W-2:0] bin_sr;
    logic [CNT_W-1:0] cnt;
    logic             accept, last, fault, bad_digit;

    assign bcd_shr = {1'b0, bcd_sr[BCD_W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib (bcd_shr[i*4 +: 4]),
            .adj (bcd_adj[i*4 +: 4])
        );
    end

`ifdef BCD2BIN_ERR_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_sr[i*4 +: 4] > 4'd9) bad_digit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       err <= 1'b0;
        else if (fault) err <= 1'b1;
        else if (last)  err <= 1'b0;
    end
`else
    assign bad_digit = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                // Captured digits are checked on the first SHIFT cycle, before any shifting.
                if (cnt == '0 && bad_digit) begin
                    fault     = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_sr  <= '0;
            bin_sr  <= '0;
            cnt     <= '0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bcd_sr <= bcd_in;
                bin_sr <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (fault) begin
                bin_out <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
            end else if (state == SHIFT) begin
                bcd_sr <= bcd_adj;
                bin_sr <= {bcd_sr[0], bin_sr[BIN_W-2:1]};
                cnt    <= cnt + 1'b1;
                if (last) begin
                    bin_out <= {bcd_sr[0], bin_sr};
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: latency, hold, ignore-while-busy, back-to-back, reset abort.
module tb_bcd_to_bin;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [13:0] bin_out;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;

    bcd_to_bin dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion and return in the done cycle; optional poke re-asserts start at edge N+poke.
    task automatic convert(input string tag, input logic [15:0] b, input int exp,
                           input int poke = 0, input logic [15:0] pv = 16'h0);
        int  n;
        int  bz;
        bit  seen;
        bcd_in = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bz     = busy ? 1 : 0;
        n      = 0;
        seen   = 0;
        while (n < 40 && !seen) begin
            if (poke != 0 && n + 1 == poke) begin
                start  = 1'b1;
                bcd_in = pv;
            end
            tick();
            start = 1'b0;
            n++;
            if (done) seen = 1;
            else if (busy) bz++;
        end
        chk({tag, " latency"}, seen ? n : -1, 14);
        chk({tag, " busy_cycles"}, bz, 14);
        chk({tag, " bin_out"}, 32'(bin_out), exp);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " busy_at_done"}, 32'(busy), 0);
        done_cyc = cyc;
    endtask

    task automatic after_pulse(input string tag, input int exp);
        tick();
        chk({tag, " done_single"}, 32'(done), 0);
        chk({tag, " held"}, 32'(bin_out), exp);
    endtask

    initial begin
        int first;
        int dn;

        repeat (3) tick();
        chk("rst bin_out", 32'(bin_out), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        rst = 1'b1;
        tick();

        convert("c1234", 16'h1234, 1234);
        after_pulse("c1234", 1234);
        convert("c9999", 16'h9999, 9999);
        after_pulse("c9999", 9999);
        convert("c0000", 16'h0000, 0);
        after_pulse("c0000", 0);
        convert("c8000", 16'h8000, 8000);
        convert("c0999", 16'h0999, 999);
        after_pulse("c0999", 999);

        convert("c3725", 16'h3725, 3725, 5, 16'h1111);
        after_pulse("c3725", 3725);
        repeat (20) begin
            tick();
            dn += done ? 1 : 0;
        end
        chk("ignored start no done", dn, 0);

        convert("c2468", 16'h2468, 2468);
        first = done_cyc;
        convert("c0010", 16'h0010, 10);
        chk("b2b spacing", done_cyc - first, 15);
        after_pulse("c0010", 10);

        bcd_in = 16'h1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        #1;
        chk("abort bin_out", 32'(bin_out), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort err", 32'(err), 0);
        repeat (2) tick();
        rst = 1'b1;
        dn  = 0;
        repeat (20) begin
            tick();
            dn += done ? 1 : 0;
        end
        chk("abort no done", dn, 0);
        convert("c0042", 16'h0042, 42);
        after_pulse("c0042", 42);

`ifdef BCD2BIN_ERR_EN
        bcd_in = 16'h12A4;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("bad busy", 32'(busy), 1);
        tick();
        chk("bad done", 32'(done), 1);
        chk("bad err", 32'(err), 1);
        chk("bad bin_out", 32'(bin_out), 0);
        chk("bad busy_clr", 32'(busy), 0);
        tick();
        chk("bad err_held", 32'(err), 1);
        convert("c0005", 16'h0005, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
